// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for a 5-stage in-order pipeline (load-use, redirect, mul/div, data memory).
// Latency: outputs are combinational from the registered FSM state and the current-cycle hazard inputs.
// Backpressure: memory wait and multi-cycle EX freeze upstream stages; `PIPELINE_CTRL_PERF_EN adds stall_cycles.
module pipeline_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MC_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_rs1_used,
  input  logic              ifid_rs2_used,
  input  logic              ex_redirect,
  input  logic              ex_mc_start,
  input  logic              ex_mc_done,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_stall,
  output logic              exmem_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              memwb_flush,
  output logic              mc_timeout
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  // Counter wide enough to hold MC_TIMEOUT-1 (at least one bit).
  localparam int CW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] mc_cnt, mc_cnt_nxt;

  logic load_use;
  logic mem_wait;
  logic mc_begin;

  // Ungated control terms; reset gating is applied at the ports.
  logic pc_s, ifid_s, idex_s, exmem_s;
  logic ifid_f, idex_f, exmem_f, memwb_f;
  logic mc_to;

  // A load in EX whose destination is read by the instruction in ID; x0 never hazards.
  assign load_use = idex_mem_read && (idex_rd != '0) &&
                    ((ifid_rs1_used && (ifid_rs1 == idex_rd)) ||
                     (ifid_rs2_used && (ifid_rs2 == idex_rd)));

  assign mem_wait = mem_req && !mem_ready;

  // Start and done in the same cycle is a single-cycle op: nothing to wait for.
  assign mc_begin = ex_mc_start && !ex_mc_done;

  // State and wait-counter registers; reset abandons any wait in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
    end
  end

  // Next-state and stall/flush decode; priority is memory > multi-cycle > redirect > load-use.
  always_comb begin
    state_nxt  = state;
    mc_cnt_nxt = '0;
    pc_s       = 1'b0;
    ifid_s     = 1'b0;
    idex_s     = 1'b0;
    exmem_s    = 1'b0;
    ifid_f     = 1'b0;
    idex_f     = 1'b0;
    exmem_f    = 1'b0;
    memwb_f    = 1'b0;
    mc_to      = 1'b0;

    unique case (state)
      RUN: begin
        if (mem_wait) begin
          pc_s      = 1'b1;
          ifid_s    = 1'b1;
          idex_s    = 1'b1;
          exmem_s   = 1'b1;
          memwb_f   = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (mc_begin) begin
          pc_s      = 1'b1;
          ifid_s    = 1'b1;
          idex_s    = 1'b1;
          exmem_f   = 1'b1;
          state_nxt = MC_WAIT;
        end else if (ex_redirect) begin
          // Wrong-path fetch is squashed; PC loads the redirect target.
          ifid_f = 1'b1;
          idex_f = 1'b1;
        end else if (load_use) begin
          // Hold IF/ID one cycle and inject a single bubble into EX.
          pc_s   = 1'b1;
          ifid_s = 1'b1;
          idex_f = 1'b1;
        end
      end

      MC_WAIT: begin
        // Redirect, load-use and memory wait are not acted on while EX is busy.
        if (ex_mc_done) begin
          state_nxt = RUN;
        end else if (mc_cnt == CNT_LAST) begin
          // Unit never answered: abort, drop the stalled op and resume.
          mc_to     = 1'b1;
          idex_f    = 1'b1;
          state_nxt = RUN;
        end else begin
          pc_s       = 1'b1;
          ifid_s     = 1'b1;
          idex_s     = 1'b1;
          exmem_f    = 1'b1;
          mc_cnt_nxt = mc_cnt + 1'b1;
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
        end else begin
          pc_s    = 1'b1;
          ifid_s  = 1'b1;
          idex_s  = 1'b1;
          exmem_s = 1'b1;
          memwb_f = 1'b1;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // All outputs read as zero while reset is held, independent of the inputs.
  assign pc_stall    = rst & pc_s;
  assign ifid_stall  = rst & ifid_s;
  assign idex_stall  = rst & idex_s;
  assign exmem_stall = rst & exmem_s;
  assign ifid_flush  = rst & ifid_f;
  assign idex_flush  = rst & idex_f;
  assign exmem_flush = rst & exmem_f;
  assign memwb_flush = rst & memwb_f;
  assign mc_timeout  = rst & mc_to;

`ifdef PIPELINE_CTRL_PERF_EN
  // Count cycles with the front end frozen, saturating rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (pc_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios followed by a random run,
// each cycle compared against a rule-level reference model of the controller.
module tb_pipeline_ctrl;

  localparam int AW = 5;
  localparam int TO = 8;

  // Output vector order: {pc_stall, ifid_stall, idex_stall, exmem_stall,
  //                       ifid_flush, idex_flush, exmem_flush, memwb_flush, mc_timeout}
  localparam logic [8:0] E_NONE = 9'b000000000;
  localparam logic [8:0] E_LU   = 9'b110001000;
  localparam logic [8:0] E_RD   = 9'b000011000;
  localparam logic [8:0] E_MEM  = 9'b111100010;
  localparam logic [8:0] E_MC   = 9'b111000100;
  localparam logic [8:0] E_TO   = 9'b000001001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          idex_mem_read;
  logic [AW-1:0] idex_rd, ifid_rs1, ifid_rs2;
  logic          ifid_rs1_used, ifid_rs2_used;
  logic          ex_redirect, ex_mc_start, ex_mc_done;
  logic          mem_req, mem_ready;
  logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic          mc_timeout;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  pipeline_ctrl #(.REG_AW(AW), .MC_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_rs1_used (ifid_rs1_used),
    .ifid_rs2_used (ifid_rs2_used),
    .ex_redirect   (ex_redirect),
    .ex_mc_start   (ex_mc_start),
    .ex_mc_done    (ex_mc_done),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_stall      (pc_stall),
    .ifid_stall    (ifid_stall),
    .idex_stall    (idex_stall),
    .exmem_stall   (exmem_stall),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_flush   (exmem_flush),
    .memwb_flush   (memwb_flush),
    .mc_timeout    (mc_timeout)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which wait (if any) the pipeline is in, and how long it has waited.
  bit     m_in_mc    = 1'b0;
  bit     m_in_mem   = 1'b0;
  int     m_mc_spent = 0;
  longint m_stalls   = 0;

  function automatic logic [8:0] observed();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall,
            ifid_flush, idex_flush, exmem_flush, memwb_flush, mc_timeout};
  endfunction

  function automatic logic [8:0] model_out();
    bit lu;
    lu = idex_mem_read && (idex_rd != 0) &&
         ((ifid_rs1_used && ifid_rs1 == idex_rd) || (ifid_rs2_used && ifid_rs2 == idex_rd));
    if (!rst) return E_NONE;
    if (m_in_mem) return mem_ready ? E_NONE : E_MEM;
    if (m_in_mc) begin
      if (ex_mc_done) return E_NONE;
      if (m_mc_spent == TO - 1) return E_TO;
      return E_MC;
    end
    if (mem_req && !mem_ready) return E_MEM;
    if (ex_mc_start && !ex_mc_done) return E_MC;
    if (ex_redirect) return E_RD;
    if (lu) return E_LU;
    return E_NONE;
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock: inputs already applied after a falling edge; compare, clock, advance model.
  task automatic cycle(input string tag, input bit use_lit, input logic [8:0] lit);
    logic [8:0] got, exp;
    #1;
    got = observed();
    exp = model_out();
    check({tag, "/model"}, got, exp);
    if (use_lit) check(tag, got, lit);
`ifdef PIPELINE_CTRL_PERF_EN
    n_cmp++;
    assert (stall_cycles === (rst ? m_stalls[31:0] : 32'd0)) else begin
      n_bad++;
      $error("FAIL %s/stall_cycles: observed %0d expected %0d", tag, stall_cycles,
             rst ? m_stalls[31:0] : 32'd0);
    end
`endif
    @(posedge clk);
    if (!rst) begin
      m_in_mc = 0; m_in_mem = 0; m_mc_spent = 0; m_stalls = 0;
    end else begin
      if (exp[8] && m_stalls < 64'h0000_0000_FFFF_FFFF) m_stalls++;
      if (m_in_mem) begin
        if (mem_ready) m_in_mem = 0;
      end else if (m_in_mc) begin
        if (ex_mc_done || m_mc_spent == TO - 1) m_in_mc = 0;
        else m_mc_spent++;
      end else if (mem_req && !mem_ready) begin
        m_in_mem = 1;
      end else if (ex_mc_start && !ex_mc_done) begin
        m_in_mc = 1;
        m_mc_spent = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    idex_mem_read = 0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
    ifid_rs1_used = 0; ifid_rs2_used = 0; ex_redirect = 0;
    ex_mc_start = 0; ex_mc_done = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_load_use();
    idex_mem_read = 1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_rs1_used = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    @(negedge clk);
    cycle("reset", 1, E_NONE);
    cycle("reset_hold", 1, E_NONE);
    rst = 1;
    cycle("idle", 1, E_NONE);

    // Load-use detection and its exceptions
    set_load_use();                               cycle("lu_rs1", 1, E_LU);
    idle();                                       cycle("lu_bubble", 1, E_NONE);
    idex_mem_read = 1; ifid_rs1_used = 1;         cycle("lu_rd0", 1, E_NONE);
    idle(); idex_mem_read = 1; idex_rd = 5'd9; ifid_rs2 = 5'd9; ifid_rs2_used = 1;
                                                  cycle("lu_rs2", 1, E_LU);
    ifid_rs2_used = 0;                            cycle("lu_unused", 1, E_NONE);
    ifid_rs2_used = 1; idex_mem_read = 0;         cycle("lu_noload", 1, E_NONE);

    // Redirect wins over load-use
    idle(); set_load_use(); ex_redirect = 1;      cycle("redir_lu", 1, E_RD);

    // Multi-cycle op: start, four waiting cycles, then done
    idle(); ex_mc_start = 1;                      cycle("mc_start", 1, E_MC);
    ex_mc_start = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin ex_redirect = 1; set_load_use(); end
      else idle();
      cycle("mc_hold", 1, E_MC);
    end
    idle(); ex_mc_done = 1;                       cycle("mc_done", 1, E_NONE);
    idle(); ex_redirect = 1;                      cycle("mc_back_run", 1, E_RD);

    // Start and done together is a single-cycle op
    idle(); ex_mc_start = 1; ex_mc_done = 1;      cycle("mc_single", 1, E_NONE);
    idle(); set_load_use();                       cycle("mc_single_run", 1, E_LU);

    // Timeout: no done; memory wait raised inside MC_WAIT is ignored
    idle(); ex_mc_start = 1;                      cycle("to_start", 1, E_MC);
    for (int i = 0; i < TO - 1; i++) begin
      idle();
      if (i < 3) mem_req = 1;
      cycle("to_hold", 1, E_MC);
    end
    idle();                                       cycle("to_pulse", 1, E_TO);
    idle();                                       cycle("to_after", 1, E_NONE);
    set_load_use();                               cycle("to_run", 1, E_LU);

    // Memory wait: three cycles not ready, multi-cycle start and redirect ignored
    idle(); mem_req = 1;                          cycle("mem_1", 1, E_MEM);
    ex_mc_start = 1;                              cycle("mem_2", 1, E_MEM);
    ex_mc_start = 0; ex_redirect = 1;             cycle("mem_3", 1, E_MEM);
    ex_redirect = 0; mem_ready = 1;               cycle("mem_ready", 1, E_NONE);
    idle();                                       cycle("mem_run", 1, E_NONE);

    // Priority: memory over multi-cycle over redirect
    idle(); mem_req = 1; ex_mc_start = 1; ex_redirect = 1; set_load_use();
                                                  cycle("prio_mem", 1, E_MEM);
    idle(); mem_ready = 1;                        cycle("prio_mem_end", 1, E_NONE);
    idle(); ex_mc_start = 1; ex_redirect = 1; set_load_use();
                                                  cycle("prio_mc", 1, E_MC);
    idle(); ex_mc_done = 1;                       cycle("prio_mc_end", 1, E_NONE);

    // Reset in the middle of MC_WAIT and of MEM_WAIT
    idle(); ex_mc_start = 1;                      cycle("rst_mc_start", 1, E_MC);
    idle();                                       cycle("rst_mc_hold", 1, E_MC);
    rst = 0;                                      cycle("rst_mid_mc", 1, E_NONE);
    rst = 1;                                      cycle("rst_mc_release", 1, E_NONE);
    set_load_use();                               cycle("rst_mc_run", 1, E_LU);
    idle(); mem_req = 1;                          cycle("rst_mem_start", 1, E_MEM);
    rst = 0;                                      cycle("rst_mid_mem", 1, E_NONE);
    rst = 1; idle();                              cycle("rst_mem_release", 1, E_NONE);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      idex_mem_read = 1'($urandom_range(0, 1));
      idex_rd       = AW'($urandom_range(0, 3));
      ifid_rs1      = AW'($urandom_range(0, 3));
      ifid_rs2      = AW'($urandom_range(0, 3));
      ifid_rs1_used = 1'($urandom_range(0, 1));
      ifid_rs2_used = 1'($urandom_range(0, 1));
      ex_redirect   = ($urandom_range(0, 3) == 0);
      ex_mc_start   = ($urandom_range(0, 5) == 0);
      ex_mc_done    = ($urandom_range(0, 6) == 0);
      mem_req       = ($urandom_range(0, 3) == 0);
      mem_ready     = 1'($urandom_range(0, 1));
      cycle("rand", 0, E_NONE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
